// File: rtl/lvdc_capture_pkg.sv
// Shared state type, parameter defaults and counter width for the LVDC serial capture block.
// The PAR state is present only when LVDC_CAPTURE_PARITY_EN is defined.
package lvdc_capture_pkg;

  localparam int WIDTH_DEF     = 26;
  localparam int NCH_DEF       = 1;
  localparam int LEAD_DEF      = 1;
  localparam int MSB_FIRST_DEF = 1;

  // Wide enough for LEAD (max 15) and any WIDTH up to 255
  localparam int CNT_W = 8;

`ifdef LVDC_CAPTURE_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAR   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/lvdc_sync_edge.sv
// Two-flop synchronizer for the bundled strobe/frame/data lines plus strobe and frame-start detection.
// Keeping all lines in one register vector preserves their relative alignment.
module lvdc_sync_edge #(
  parameter int NCH = 1
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           sclk,
  input  logic           frame,
  input  logic [NCH-1:0] sdata,
  output logic           strobe,
  output logic           frame_start,
  output logic [NCH-1:0] data
);

  localparam int W = NCH + 2;

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;
  logic         sclk_prev_reg;
  logic         frame_prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg       <= '0;
      sync_reg       <= '0;
      sclk_prev_reg  <= 1'b0;
      frame_prev_reg <= 1'b0;
    end else begin
      meta_reg      <= {sdata, frame, sclk};
      sync_reg      <= meta_reg;
      sclk_prev_reg <= sync_reg[0];
      // FRAME history only advances on strobe events, so a rise is judged strobe-to-strobe
      if (strobe) frame_prev_reg <= sync_reg[1];
    end
  end

  assign strobe      = sync_reg[0] & ~sclk_prev_reg;
  assign frame_start = strobe & sync_reg[1] & ~frame_prev_reg;
  assign data        = sync_reg[W-1:2];

endmodule

// File: rtl/lvdc_serial_capture.sv
// Multi-channel serial word capture with frame alignment, ready/valid output and overrun flag.
// Optional odd-parity check per channel is enabled by defining LVDC_CAPTURE_PARITY_EN.
module lvdc_serial_capture
  import lvdc_capture_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int LEAD      = LEAD_DEF,
  parameter int MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 SCLK,
  input  logic                 FRAME,
  input  logic [NCH-1:0]       SDATA,
  output logic [NCH*WIDTH-1:0] WORD,
  output logic                 WORD_VALID,
  input  logic                 WORD_READY,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output logic [NCH-1:0]       PAR_ERR
);

  logic           strobe;
  logic           frame_start;
  logic [NCH-1:0] sdata_s;

  lvdc_sync_edge #(.NCH(NCH)) u_sync_edge (
    .clk         (SIM_CLK),
    .srst        (SIM_RST),
    .sclk        (SCLK),
    .frame       (FRAME),
    .sdata       (SDATA),
    .strobe      (strobe),
    .frame_start (frame_start),
    .data        (sdata_s)
  );

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [NCH*WIDTH-1:0]   shift_reg, shift_next, shifted;
  logic [NCH*WIDTH-1:0]   word_reg;
  logic                   valid_reg;
  logic                   overrun_reg;
  logic                   complete;

  // Per-channel shift: MSB-first shifts left, LSB-first shifts right from the top
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [WIDTH-1:0] cur;
    assign cur = shift_reg[gi*WIDTH +: WIDTH];
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted[gi*WIDTH +: WIDTH] = (cur << 1) | WIDTH'(sdata_s[gi]);
    end else begin : g_lsb
      assign shifted[gi*WIDTH +: WIDTH] = (cur >> 1) | (WIDTH'(sdata_s[gi]) << (WIDTH - 1));
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    complete   = 1'b0;
    if (strobe) begin
      if (frame_start) begin
        shift_next = '0;
        if (LEAD > 0) begin
          state_next = ST_LEAD;
          cnt_next   = CNT_W'(LEAD);
        end else begin
          state_next = ST_SHIFT;
          cnt_next   = CNT_W'(WIDTH);
        end
      end else begin
        case (state_reg)
          ST_LEAD: begin
            if (cnt_reg == CNT_W'(1)) begin
              state_next = ST_SHIFT;
              cnt_next   = CNT_W'(WIDTH);
            end else begin
              cnt_next = cnt_reg - CNT_W'(1);
            end
          end
          ST_SHIFT: begin
            shift_next = shifted;
            if (cnt_reg == CNT_W'(1)) begin
              cnt_next = '0;
`ifdef LVDC_CAPTURE_PARITY_EN
              state_next = ST_PAR;
`else
              state_next = ST_IDLE;
              complete   = 1'b1;
`endif
            end else begin
              cnt_next = cnt_reg - CNT_W'(1);
            end
          end
`ifdef LVDC_CAPTURE_PARITY_EN
          ST_PAR: begin
            state_next = ST_IDLE;
            complete   = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      word_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      if (complete) begin
        word_reg  <= shift_next;
        valid_reg <= 1'b1;
        if (valid_reg && !WORD_READY) overrun_reg <= 1'b1;
      end else if (WORD_READY) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef LVDC_CAPTURE_PARITY_EN
  logic [NCH-1:0] par_bad;
  logic [NCH-1:0] par_err_reg;

  // In PAR the shift register holds the full word and the synchronized data is the parity bit
  for (genvar gi = 0; gi < NCH; gi++) begin : g_par
    assign par_bad[gi] = ~(^shift_reg[gi*WIDTH +: WIDTH] ^ sdata_s[gi]);
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      par_err_reg <= '0;
    end else if (complete) begin
      par_err_reg <= par_bad;
    end
  end

  assign PAR_ERR = par_err_reg;
`else
  assign PAR_ERR = '0;
`endif

  assign WORD       = word_reg;
  assign WORD_VALID = valid_reg;
  assign OVERRUN    = overrun_reg;
  assign BUSY       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_lvdc_serial_capture.sv
// Directed and randomized bench for lvdc_serial_capture: a default instance and an NCH=3/WIDTH=8 LSB-first instance.
// Build with LVDC_CAPTURE_PARITY_EN defined to exercise the parity path.
module tb_lvdc_serial_capture;

  localparam int WA = 26;
  localparam int WB = 8;
  localparam int NB = 3;
`ifdef LVDC_CAPTURE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          frame = 1'b0;
  logic          sda = 1'b0;
  logic [NB-1:0] sdb = '0;
  logic          rdy_a = 1'b0;
  logic          rdy_b = 1'b0;

  logic [WA-1:0]    word_a;
  logic             valid_a, busy_a, ovr_a;
  logic [0:0]       pe_a;
  logic [NB*WB-1:0] word_b;
  logic             valid_b, busy_b, ovr_b;
  logic [NB-1:0]    pe_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  lvdc_serial_capture dut_a (
    .SIM_CLK(clk), .SIM_RST(rst), .SCLK(sclk), .FRAME(frame), .SDATA(sda),
    .WORD(word_a), .WORD_VALID(valid_a), .WORD_READY(rdy_a),
    .BUSY(busy_a), .OVERRUN(ovr_a), .PAR_ERR(pe_a)
  );

  lvdc_serial_capture #(.WIDTH(WB), .NCH(NB), .LEAD(1), .MSB_FIRST(0)) dut_b (
    .SIM_CLK(clk), .SIM_RST(rst), .SCLK(sclk), .FRAME(frame), .SDATA(sdb),
    .WORD(word_b), .WORD_VALID(valid_b), .WORD_READY(rdy_b),
    .BUSY(busy_b), .OVERRUN(ovr_b), .PAR_ERR(pe_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe: raise SCLK with data/frame, hold, then drop
  task automatic pulse(input logic a, input logic [NB-1:0] b, input logic f);
    @(negedge clk);
    sclk = 1'b1; sda = a; sdb = b; frame = f;
    repeat (3) @(negedge clk);
    sclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Final strobe with latency check on instance A: valid must appear exactly one cycle after the strobe event
  task automatic last_pulse(input logic a, input logic [NB-1:0] b);
    @(negedge clk);
    sclk = 1'b1; sda = a; sdb = b; frame = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("latency_valid_low", 64'(valid_a), 64'd0);
    @(posedge clk); #1;
    chk("latency_valid_high", 64'(valid_a), 64'd1);
    @(negedge clk);
    sclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Frame strobe, one lead strobe, then nbits data strobes. A gets a MSB-first, then pa;
  // B channel c gets b[c] LSB-first, then pb.
  task automatic send(input logic [WA-1:0] a, input logic [NB*WB-1:0] b, input int nbits,
                      input logic pa, input logic [NB-1:0] pb, input bit timing);
    pulse(1'b0, '0, 1'b1);
    pulse(1'b0, '0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      logic          da;
      logic [NB-1:0] db;
      da = pa;
      db = '0;
      if (i < WA) da = a[WA-1-i];
      if (i < WB) begin
        for (int c = 0; c < NB; c++) db[c] = b[c*WB+i];
      end else if (i == WB) begin
        db = pb;
      end
      if (timing && i == nbits - 1) last_pulse(da, db);
      else pulse(da, db, 1'b0);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic accept_a();
    @(negedge clk); rdy_a = 1'b1;
    @(negedge clk); rdy_a = 1'b0;
  endtask

  task automatic accept_b();
    @(negedge clk); rdy_b = 1'b1;
    @(negedge clk); rdy_b = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
  endtask

  // Expected odd-parity error: total ones over word plus parity bit must be odd
  function automatic logic odd_fail(input logic [WA-1:0] w, input logic p);
    return ((^w) ^ p) == 1'b0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WA-1:0]    w, w2, w3;
    logic [NB*WB-1:0] bw;
    logic             pa;
    logic [NB-1:0]    pb, exp_pb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_word", 64'(word_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_overrun", 64'(ovr_a), 64'd0);
    chk("rst_par_err", 64'(pe_a), 64'd0);
    chk("rst_word_b", 64'(word_b), 64'd0);

    // Directed 0x2AAAAAA MSB-first with latency and hold checks
    w = 26'h2AAAAAA;
    send(w, '0, WA + PAR, ~(^w), '0, 1'b1);
    chk("t1_word", 64'(word_a), 64'(w));
    chk("t1_busy", 64'(busy_a), 64'd0);
    chk("t1_par_err", 64'(pe_a), 64'd0);
    repeat (10) @(negedge clk);
    chk("t1_hold_valid", 64'(valid_a), 64'd1);
    chk("t1_hold_word", 64'(word_a), 64'(w));
    accept_a();
    chk("t1_accept_valid", 64'(valid_a), 64'd0);

    // Random words with random parity bit
    for (int k = 0; k < 3; k++) begin
      w  = WA'($urandom);
      pa = 1'($urandom);
      send(w, '0, WA + PAR, pa, '0, 1'b0);
      chk("rand_a_word", 64'(word_a), 64'(w));
      chk("rand_a_valid", 64'(valid_a), 64'd1);
      chk("rand_a_par_err", 64'(pe_a), 64'((PAR != 0) && odd_fail(w, pa)));
      accept_a();
    end

    // Overrun: two words without accept
    w  = WA'($urandom);
    w2 = WA'($urandom);
    send(w, '0, WA + PAR, ~(^w), '0, 1'b0);
    chk("ovr_first_ovr", 64'(ovr_a), 64'd0);
    send(w2, '0, WA + PAR, ~(^w2), '0, 1'b0);
    chk("ovr_word", 64'(word_a), 64'(w2));
    chk("ovr_valid", 64'(valid_a), 64'd1);
    chk("ovr_flag", 64'(ovr_a), 64'd1);
    accept_a();
    chk("ovr_sticky", 64'(ovr_a), 64'd1);

    // Frame re-rises after 10 bits
    w  = WA'($urandom);
    w2 = WA'($urandom);
    send(w, '0, 10, 1'b0, '0, 1'b0);
    chk("abort_valid", 64'(valid_a), 64'd0);
    chk("abort_busy", 64'(busy_a), 64'd1);
    send(w2, '0, WA + PAR, ~(^w2), '0, 1'b0);
    chk("abort_word", 64'(word_a), 64'(w2));
    chk("abort_valid_after", 64'(valid_a), 64'd1);
    accept_a();

    // Reset at bit 12
    w  = WA'($urandom);
    w3 = WA'($urandom);
    send(w, '0, 12, 1'b0, '0, 1'b0);
    do_reset();
    chk("midrst_word", 64'(word_a), 64'd0);
    chk("midrst_valid", 64'(valid_a), 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_overrun", 64'(ovr_a), 64'd0);
    chk("midrst_par_err", 64'(pe_a), 64'd0);
    send(w3, '0, WA + PAR, ~(^w3), '0, 1'b0);
    chk("midrst_next_word", 64'(word_a), 64'(w3));
    chk("midrst_next_valid", 64'(valid_a), 64'd1);
    accept_a();

    // Three channels, LSB-first, 8 bits
    do_reset();
    bw = {8'h01, 8'hFF, 8'h5A};
    pb = {~(^bw[23:16]), ~(^bw[15:8]), ~(^bw[7:0])};
    send('0, bw, WB + PAR, 1'b0, pb, 1'b0);
    chk("b_dir_word", 64'(word_b), 64'h01FF5A);
    chk("b_dir_valid", 64'(valid_b), 64'd1);
    chk("b_dir_par_err", 64'(pe_b), 64'd0);
    accept_b();

    for (int k = 0; k < 3; k++) begin
      bw = (NB*WB)'($urandom);
      pb = NB'($urandom);
      for (int c = 0; c < NB; c++)
        exp_pb[c] = (PAR != 0) && odd_fail(WA'(bw[c*WB +: WB]), pb[c]);
      send('0, bw, WB + PAR, 1'b0, pb, 1'b0);
      chk("b_rand_word", 64'(word_b), 64'(bw));
      chk("b_rand_par_err", 64'(pe_b), 64'(exp_pb));
      accept_b();
    end

`ifdef LVDC_CAPTURE_PARITY_EN
    // 0x03 on channel 0 with parity 0 fails odd parity; with parity 1 it passes
    bw = {8'h00, 8'h00, 8'h03};
    send('0, bw, WB + 1, 1'b0, 3'b110, 1'b0);
    chk("par_bad_word", 64'(word_b), 64'h000003);
    chk("par_bad_err", 64'(pe_b), 64'b001);
    accept_b();
    send('0, bw, WB + 1, 1'b0, 3'b111, 1'b0);
    chk("par_good_err", 64'(pe_b), 64'b000);
    accept_b();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
